// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the N-stage MIPS pipeline: scoreboard of in-flight writes,
// stall/bubble/forward selects. Optional perf counters built only when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter  int NSTAGE = 3,
    parameter  int AW     = 5,
    parameter  int TW     = 2,
    localparam int FW     = $clog2(NSTAGE + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          exc_flush,
    input  logic          id_valid,
    input  logic [AW-1:0] id_a1,
    input  logic [AW-1:0] id_a2,
    input  logic [TW-1:0] id_tuse_rs,
    input  logic [TW-1:0] id_tuse_rt,
    input  logic [AW-1:0] id_a3,
    input  logic [TW-1:0] id_tnew,
    input  logic          id_sys,
    input  logic          id_serial,
    input  logic          id_md,
    input  logic          md_start,
    input  logic          md_busy,
    output logic          stall,
    output logic          pc_en,
    output logic          d_en,
    output logic          e_clr,
    output logic          md_stall,
    output logic [FW-1:0] fsel_rs_d,
    output logic [FW-1:0] fsel_rt_d,
    output logic [FW-1:0] fsel_rs_e,
    output logic [FW-1:0] fsel_rt_e,
    output logic [31:0]   perf_stall_cnt,
    output logic [31:0]   perf_md_cnt
);

    typedef struct packed {
        logic          v;
        logic [AW-1:0] a3;
        logic [TW-1:0] tnew;
        logic          sys;
    } entry_t;

    entry_t        entry_q [NSTAGE];
    entry_t        entry_d [NSTAGE];
    logic [AW-1:0] a1_q, a1_d;
    logic [AW-1:0] a2_q, a2_d;

    logic data_hz;
    logic md_hz;
    logic serial_hz;
    logic rs_used;
    logic rt_used;

    function automatic logic src_match(input entry_t e, input logic [AW-1:0] src);
        return e.v && (e.a3 != '0) && (e.a3 == src);
    endfunction

    // Descending scan so the youngest (lowest index) matching entry is written last and wins.
    always_comb begin
        data_hz   = 1'b0;
        serial_hz = 1'b0;
        fsel_rs_d = '0;
        fsel_rt_d = '0;
        fsel_rs_e = '0;
        fsel_rt_e = '0;
        rs_used   = (id_tuse_rs != '1);
        rt_used   = (id_tuse_rt != '1);
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (rs_used && src_match(entry_q[k], id_a1) && (entry_q[k].tnew > id_tuse_rs))
                data_hz = 1'b1;
            if (rt_used && src_match(entry_q[k], id_a2) && (entry_q[k].tnew > id_tuse_rt))
                data_hz = 1'b1;
            if (src_match(entry_q[k], id_a1) && (entry_q[k].tnew == '0))
                fsel_rs_d = FW'(k + 1);
            if (src_match(entry_q[k], id_a2) && (entry_q[k].tnew == '0))
                fsel_rt_d = FW'(k + 1);
            if ((k <= NSTAGE - 2) && entry_q[k].v && entry_q[k].sys)
                serial_hz = 1'b1;
            if ((k >= 1) && src_match(entry_q[k], a1_q) && (entry_q[k].tnew == '0))
                fsel_rs_e = FW'(k + 1);
            if ((k >= 1) && src_match(entry_q[k], a2_q) && (entry_q[k].tnew == '0))
                fsel_rt_e = FW'(k + 1);
        end
        data_hz   = data_hz & id_valid;
        md_hz     = id_valid & id_md & (md_start | md_busy);
        serial_hz = serial_hz & id_valid & id_serial;
    end

    // Reset gating makes an asserted reset release any stall before the next edge.
    always_comb begin
        stall    = (data_hz | md_hz | serial_hz) & ~exc_flush & ~reset;
        md_stall = md_hz & ~data_hz & ~exc_flush & ~reset;
        e_clr    = (stall | exc_flush) & ~reset;
        pc_en    = ~stall | exc_flush;
        d_en     = ~stall | exc_flush;
    end

    always_comb begin
        for (int k = 0; k < NSTAGE; k++)
            entry_d[k] = '0;
        a1_d = '0;
        a2_d = '0;
        if (!exc_flush) begin
            if (!stall) begin
                entry_d[0].v    = id_valid;
                entry_d[0].a3   = id_a3;
                entry_d[0].tnew = id_tnew;
                entry_d[0].sys  = id_sys;
                a1_d            = id_a1;
                a2_d            = id_a2;
            end
            for (int k = 1; k < NSTAGE; k++) begin
                entry_d[k]      = entry_q[k-1];
                entry_d[k].tnew = (entry_q[k-1].tnew != '0) ? entry_q[k-1].tnew - TW'(1) : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NSTAGE; k++)
                entry_q[k] <= '0;
            a1_q <= '0;
            a2_q <= '0;
        end else begin
            for (int k = 0; k < NSTAGE; k++)
                entry_q[k] <= entry_d[k];
            a1_q <= a1_d;
            a2_q <= a2_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_md_q, perf_md_d;

    // Saturating event counters; a flush leaves them untouched.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_md_d    = perf_md_q;
        if (stall && (perf_stall_q != 32'hFFFF_FFFF))
            perf_stall_d = perf_stall_q + 32'd1;
        if (md_stall && (perf_md_q != 32'hFFFF_FFFF))
            perf_md_d = perf_md_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_md_q    <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_md_q    <= perf_md_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_md_cnt    = perf_md_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_md_cnt    = 32'd0;
`endif

endmodule
